// File: rtl/mul_wide_iter_if.sv
// Operand/result handshake bundle for the iterative wide multiplier.
interface mul_wide_iter_if #(
    parameter int unsigned WIDTH = 256
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    // Producer/consumer side (operand registers and reduction controller)
    modport master (
        output in_valid, a, b, flush, out_ready,
        input  in_ready, out_valid, p, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, flush, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mul_wide_iter.sv
// Iterative unsigned WIDTH x WIDTH multiplier built around one LIMB x LIMB
// product unit, walking all N*N limb pairs and accumulating shifted partial
// products into a 2*WIDTH accumulator. WIDTH must be a multiple of LIMB.
module mul_wide_iter #(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned LIMB    = 64,
    parameter int unsigned MUL_REG = 0
) (
    input  logic           clk,
    input  logic           rst,
    mul_wide_iter_if.slave bus
);
    localparam int unsigned N     = WIDTH / LIMB;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned LW    = 2 * LIMB;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SH_W  = $clog2(PW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Datapath registers
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc;
    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic [LW-1:0]    prod_q;
    logic [SH_W-1:0]  sh_q;

    // Registered outputs
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [PW-1:0]    p_q;

    // Combinational helpers
    logic             accept_c;
    logic             calc_c;
    logic             drain_c;
    logic             last_pair_c;
    logic [LIMB-1:0]  limb_a_c;
    logic [LIMB-1:0]  limb_b_c;
    logic [LW-1:0]    prod_c;
    logic [SH_W-1:0]  shamt_c;
    logic [PW-1:0]    addend_c;
    logic [PW-1:0]    acc_sum_c;

    // Limb select, single product unit, and the shifted accumulate
    always_comb begin
        limb_a_c    = LIMB'(a_q >> (LIMB * 32'(i_q)));
        limb_b_c    = LIMB'(b_q >> (LIMB * 32'(j_q)));
        prod_c      = LW'(limb_a_c) * LW'(limb_b_c);
        shamt_c     = SH_W'(LIMB * (32'(i_q) + 32'(j_q)));
        last_pair_c = (i_q == LAST_IDX) && (j_q == LAST_IDX);
        if (MUL_REG != 0) begin
            // registered product lags one cycle together with its shift
            addend_c = PW'(prod_q) << sh_q;
        end else begin
            addend_c = PW'(prod_c) << shamt_c;
        end
        acc_sum_c = acc + addend_c;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; flush overrides every other request
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        calc_c    = 1'b0;
        drain_c   = 1'b0;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        accept_c  = 1'b1;
                        state_nxt = CALC;
                    end
                end
                CALC: begin
                    calc_c = 1'b1;
                    if (last_pair_c) begin
                        state_nxt = (MUL_REG != 0) ? DRAIN : DONE;
                    end
                end
                DRAIN: begin
                    drain_c   = 1'b1;
                    state_nxt = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand latch, limb walk and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            prod_q <= '0;
            sh_q   <= '0;
        end else if (accept_c) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            acc    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            prod_q <= '0;
            sh_q   <= '0;
        end else if (calc_c) begin
            acc    <= acc_sum_c;
            prod_q <= prod_c;
            sh_q   <= shamt_c;
            if (!last_pair_c) begin
                if (j_q == LAST_IDX) begin
                    j_q <= '0;
                    i_q <= i_q + IDX_W'(1);
                end else begin
                    j_q <= j_q + IDX_W'(1);
                end
            end
        end else if (drain_c) begin
            acc <= acc_sum_c;
        end
    end

    // Status outputs follow the next state; p loads only on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            p_q         <= '0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
            busy_q      <= (state_nxt == CALC) || (state_nxt == DRAIN);
            if ((state_nxt == DONE) && (state != DONE)) begin
                p_q <= acc_sum_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.p         = p_q;

endmodule

// File: tb/tb_mul_wide_iter.sv
// Bench for mul_wide_iter: directed cases on the 256/64 build, random traffic
// on a registered-product build and a single-limb build, all checked each
// cycle against a latency-level behavioural model.
module tb_mul_wide_iter;
    localparam int RAND_CYC = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst1;
    logic rst2;
    logic drv1_done = 1'b0;
    logic drv2_done = 1'b0;

    int checks   = 0;
    int failures = 0;

    mul_wide_iter_if #(.WIDTH(256)) bus0 ();
    mul_wide_iter_if #(.WIDTH(256)) bus1 ();
    mul_wide_iter_if #(.WIDTH(64))  bus2 ();

    mul_wide_iter #(.WIDTH(256), .LIMB(64), .MUL_REG(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    mul_wide_iter #(.WIDTH(256), .LIMB(64), .MUL_REG(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    mul_wide_iter #(.WIDTH(64),  .LIMB(64), .MUL_REG(0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    // Behavioural model: one in-flight op per DUT, result due lat clocks after accept
    int           m_lat  [3] = '{16, 17, 1};
    logic         m_pend [3] = '{1'b0, 1'b0, 1'b0};
    int           m_cyc  [3] = '{0, 0, 0};
    logic [511:0] m_cur  [3];
    logic [511:0] m_p    [3];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic iv,
                              input logic [511:0] av, input logic [511:0] bv,
                              input logic fl, input logic ordy,
                              input logic ir, input logic ov, input logic bs,
                              input logic [511:0] pv);
        if (r) begin
            m_pend[k] = 1'b0;
            m_cyc[k]  = 0;
            m_p[k]    = '0;
        end
        chk($sformatf("dut%0d in_ready", k),  512'(ir), 512'(!m_pend[k]));
        chk($sformatf("dut%0d out_valid", k), 512'(ov), 512'(m_pend[k] && (m_cyc[k] == m_lat[k])));
        chk($sformatf("dut%0d busy", k),      512'(bs), 512'(m_pend[k] && (m_cyc[k] < m_lat[k])));
        chk($sformatf("dut%0d p", k),         pv,       m_p[k]);
        if (!r) begin
            if (fl) begin
                m_pend[k] = 1'b0;
            end else if (!m_pend[k]) begin
                if (iv) begin
                    m_pend[k] = 1'b1;
                    m_cyc[k]  = 0;
                    m_cur[k]  = av * bv;
                end
            end else if (m_cyc[k] < m_lat[k]) begin
                m_cyc[k]++;
                if (m_cyc[k] == m_lat[k]) m_p[k] = m_cur[k];
            end else if (ordy) begin
                m_pend[k] = 1'b0;
            end
        end
    endtask

    // Compare process: inputs are stable mid-cycle, outputs reflect the last edge
    always @(negedge clk) begin
        model_step(0, rst0, bus0.in_valid, 512'(bus0.a), 512'(bus0.b), bus0.flush,
                   bus0.out_ready, bus0.in_ready, bus0.out_valid, bus0.busy, 512'(bus0.p));
        model_step(1, rst1, bus1.in_valid, 512'(bus1.a), 512'(bus1.b), bus1.flush,
                   bus1.out_ready, bus1.in_ready, bus1.out_valid, bus1.busy, 512'(bus1.p));
        model_step(2, rst2, bus2.in_valid, 512'(bus2.a), 512'(bus2.b), bus2.flush,
                   bus2.out_ready, bus2.in_ready, bus2.out_valid, bus2.busy, 512'(bus2.p));
    end

    function automatic logic [255:0] rand_op();
        logic [255:0] v;
        int unsigned  m = $urandom_range(0, 7);
        v = '0;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
        if (m == 0)      v = '1;
        else if (m == 1) v = '0;
        else if (m == 2) v = 256'(1) << $urandom_range(0, 255);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op on dut0 with literal expectations; hold>0 stalls the consumer in DONE
    task automatic run_op(input string name, input logic [255:0] av, input logic [255:0] bv,
                          input logic [511:0] exp, input int hold);
        int w;
        int lat;
        w = 0;
        while (!bus0.in_ready && w < 50) begin
            step();
            w++;
        end
        chk({name, " ready"}, 512'(bus0.in_ready), 512'(1));
        bus0.a         = av;
        bus0.b         = bv;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = (hold == 0);
        step();
        bus0.in_valid = 1'b0;
        lat = 0;
        while (!bus0.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({name, " latency"}, 512'(lat), 512'(16));
        chk({name, " p"}, bus0.p, exp);
        for (int h = 0; h < hold; h++) begin
            bus0.in_valid = 1'b1;
            bus0.a        = rand_op();
            bus0.b        = rand_op();
            step();
            chk({name, " hold p"}, bus0.p, exp);
            chk({name, " hold in_ready"}, 512'(bus0.in_ready), 512'(0));
            chk({name, " hold out_valid"}, 512'(bus0.out_valid), 512'(1));
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        chk({name, " pulse end"}, 512'(bus0.out_valid), 512'(0));
        chk({name, " idle busy"}, 512'(bus0.busy), 512'(0));
        chk({name, " idle ready"}, 512'(bus0.in_ready), 512'(1));
    endtask

    // Directed sequence on the 256/64 build, then the summary
    initial begin : drv0
        logic [511:0] exp_ones;
        rst0           = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.flush     = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        step();
        chk("reset in_ready",  512'(bus0.in_ready),  512'(1));
        chk("reset out_valid", 512'(bus0.out_valid), 512'(0));
        chk("reset busy",      512'(bus0.busy),      512'(0));
        chk("reset p",         bus0.p,               512'(0));
        rst0 = 1'b0;
        step();

        // (2^256-1)^2 = 2^512 - 2^257 + 1
        exp_ones = ~512'(0) - (512'(1) << 257) + 512'd2;
        run_op("t1 ones", '1, '1, exp_ones, 0);

        run_op("t2 shift", 256'(1) << 64, 256'(1) << 192, 512'(1) << 256, 0);
        run_op("t2 zero", 256'(0), 256'h1234, 512'(0), 0);

        run_op("t3 stall", 256'hFFFF, 256'h10001, 512'hFFFF_FFFF, 5);

        // Flush in the 7th CALC cycle
        bus0.a        = rand_op();
        bus0.b        = rand_op();
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        repeat (6) step();
        chk("t4 busy before flush", 512'(bus0.busy), 512'(1));
        bus0.flush = 1'b1;
        step();
        bus0.flush = 1'b0;
        chk("t4 flush busy",     512'(bus0.busy),      512'(0));
        chk("t4 flush in_ready", 512'(bus0.in_ready),  512'(1));
        chk("t4 flush p kept",   bus0.p,               512'hFFFF_FFFF);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t4 no out_valid", 512'(bus0.out_valid), 512'(0));
        end
        run_op("t4 3x5", 256'd3, 256'd5, 512'd15, 0);

        // Asynchronous reset in mid-CALC
        bus0.a        = rand_op();
        bus0.b        = rand_op();
        bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        repeat (5) step();
        rst0 = 1'b1;
        #1;
        chk("t5 rst out_valid", 512'(bus0.out_valid), 512'(0));
        chk("t5 rst p",         bus0.p,               512'(0));
        chk("t5 rst busy",      512'(bus0.busy),      512'(0));
        chk("t5 rst in_ready",  512'(bus0.in_ready),  512'(1));
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        step();
        run_op("t5 2^255 sq", 256'(1) << 255, 256'(1) << 255, 512'(1) << 510, 0);

        // Random ops on this build as well
        for (int n = 0; n < 6; n++) begin
            bus0.a        = rand_op();
            bus0.b        = rand_op();
            bus0.in_valid = 1'b1;
            repeat (18) step();
        end
        bus0.in_valid = 1'b0;

        wait (drv1_done && drv2_done);
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Random traffic on the registered-product build
    initial begin : drv1
        rst1           = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.flush     = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (3) step();
        rst1 = 1'b0;
        repeat (RAND_CYC) begin
            bus1.a         = rand_op();
            bus1.b         = rand_op();
            bus1.in_valid  = ($urandom_range(0, 3) != 0);
            bus1.out_ready = ($urandom_range(0, 2) != 0);
            bus1.flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        bus1.in_valid = 1'b0;
        bus1.flush    = 1'b0;
        drv1_done     = 1'b1;
    end

    // Random traffic on the single-limb build
    initial begin : drv2
        logic [255:0] ra;
        logic [255:0] rb;
        rst2           = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.a         = '0;
        bus2.b         = '0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b0;
        repeat (3) step();
        rst2 = 1'b0;
        repeat (RAND_CYC) begin
            ra             = rand_op();
            rb             = rand_op();
            bus2.a         = ra[63:0];
            bus2.b         = rb[63:0];
            bus2.in_valid  = ($urandom_range(0, 3) != 0);
            bus2.out_ready = ($urandom_range(0, 2) != 0);
            bus2.flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        bus2.in_valid = 1'b0;
        bus2.flush    = 1'b0;
        drv2_done     = 1'b1;
    end

    // Absolute time bound
    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
